dma_channel_arbiter: RTL and testbench

Downstream stage of the read-channel configuration FSM. It collects per-channel descriptors (ID, priority, transfer size in beats), then arbitrates among pending channels and issues one burst grant at a time to the read/write transfer engine. It reports each channel's completion (`ch_done`/`ch_id`) and signals `arbWriteTransactionsDone` once every pending channel has drained.

---
 rtl/dma_arb_pkg.sv | 23 ++
 rtl/dma_arb_pick.sv | 44 ++++
 rtl/dma_channel_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and widths for the DMA channel arbiter.
package dma_arb_pkg;

  localparam int unsigned CH_ID_W = 6;
  localparam int unsigned BEATS_W = 5;
  localparam int unsigned PRIO_W  = 4;
  localparam int unsigned SIZE_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    GRANT,
    WAIT_DONE,
    UPDATE
  } arb_state_t;

  typedef struct packed {
    logic              pending;
    logic [PRIO_W-1:0] prio;
    logic [SIZE_W-1:0] remaining;
  } arb_slot_t;

endpackage

// File: rtl/dma_arb_pick.sv
// Combinational winner selection: highest priority pending slot.
// Tie-break is round-robin when DMA_ARB_ROUND_ROBIN_EN is defined, else lowest ID.
module dma_arb_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 32,
  parameter int unsigned PRIO_WIDTH   = 4,
  parameter int unsigned IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] pending,
  input  logic [PRIO_WIDTH-1:0]   prio [NUM_CHANNELS],
`ifdef DMA_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]        last,
`endif
  output logic [IDX_W-1:0]        winner,
  output logic                    any_pending
);

  logic                  found;
  logic [PRIO_WIDTH-1:0] best;
  logic [IDX_W-1:0]      sel;

  // Strict '>' keeps the first candidate in search order on a priority tie.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    best   = '0;
    sel    = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
`ifdef DMA_ARB_ROUND_ROBIN_EN
      sel = IDX_W'((32'(last) + 32'd1 + 32'(k)) % NUM_CHANNELS);
`else
      sel = IDX_W'(k);
`endif
      if (pending[sel] && (!found || (prio[sel] > best))) begin
        found  = 1'b1;
        best   = prio[sel];
        winner = sel;
      end
    end
    any_pending = |pending;
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Collects per-channel descriptors and issues one burst grant at a time.
// Optional round-robin tie-break: define DMA_ARB_ROUND_ROBIN_EN.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 32,
  parameter int unsigned MAX_BURST_BEATS = 16,
  parameter int unsigned PRIO_WIDTH      = 4
) (
  input  logic               AXI_aclk,
  input  logic               AXI_aresetn,
  input  logic               arbSample,
  input  logic [CH_ID_W-1:0] arbCurrentChannelSample,
  input  logic [PRIO_W-1:0]  arbChannelPriority,
  input  logic [SIZE_W-1:0]  arbChannelTransferSize,
  input  logic               arbitrate,
  output logic               grant_valid,
  input  logic               grant_ready,
  output logic [CH_ID_W-1:0] grant_ch,
  output logic [BEATS_W-1:0] grant_beats,
  input  logic               burst_done,
  output logic               ch_done,
  output logic [CH_ID_W-1:0] ch_id,
  output logic               arbWriteTransactionsDone
);

  localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);

  arb_state_t state, next_state;

  arb_slot_t             slots   [NUM_CHANNELS];
  arb_slot_t             slots_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending_now;
  logic [NUM_CHANNELS-1:0] pending_next;
  logic [PRIO_WIDTH-1:0] prio_vec [NUM_CHANNELS];

  logic [IDX_W-1:0]   pick_win;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   smp_idx;
  logic               any_pending;
  logic               any_after;
  logic               smp_ok;
  logic               upd_zero;
  logic               upd_done;
  logic [SIZE_W-1:0]  pick_rem;
  logic [SIZE_W-1:0]  upd_rem;
  logic [BEATS_W-1:0] pick_beats;

  logic               grant_valid_d;
  logic               ch_done_d;
  logic [CH_ID_W-1:0] ch_id_d;
  logic               wtd_d;

`ifdef DMA_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   last_q;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pending_now[i]  = slots[i].pending;
      pending_next[i] = slots_d[i].pending;
      prio_vec[i]     = PRIO_WIDTH'(slots[i].prio);
    end
  end

  dma_arb_pick #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PRIO_WIDTH   (PRIO_WIDTH),
    .IDX_W        (IDX_W)
  ) u_pick (
    .pending     (pending_now),
    .prio        (prio_vec),
`ifdef DMA_ARB_ROUND_ROBIN_EN
    .last        (last_q),
`endif
    .winner      (pick_win),
    .any_pending (any_pending)
  );

  assign smp_ok     = arbSample && (32'(arbCurrentChannelSample) < NUM_CHANNELS);
  assign smp_idx    = IDX_W'(arbCurrentChannelSample);
  assign cur_idx    = IDX_W'(grant_ch);
  assign pick_rem   = slots[pick_win].remaining;
  assign pick_beats = (pick_rem > SIZE_W'(MAX_BURST_BEATS)) ? BEATS_W'(MAX_BURST_BEATS)
                                                            : BEATS_W'(pick_rem);
  assign upd_rem    = slots[cur_idx].remaining - SIZE_W'(grant_beats);
  assign upd_zero   = (upd_rem == '0);
  // A same-cycle sample to the current slot overrides the decrement, so it did not complete.
  assign upd_done   = upd_zero && !(smp_ok && (smp_idx == cur_idx));

  // Slot next-state: decrement in UPDATE, then sample overwrite wins.
  always_comb begin
    slots_d = slots;
    if (state == UPDATE) begin
      slots_d[cur_idx].remaining = upd_rem;
      if (upd_zero) slots_d[cur_idx].pending = 1'b0;
    end
    if (smp_ok) begin
      slots_d[smp_idx].pending   = 1'b1;
      slots_d[smp_idx].prio      = arbChannelPriority;
      slots_d[smp_idx].remaining = arbChannelTransferSize;
    end
  end

  assign any_after = |pending_next;

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      for (int i = 0; i < NUM_CHANNELS; i++) slots[i] <= '0;
    end else begin
      slots <= slots_d;
    end
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (arbitrate && any_pending) next_state = PICK;
      PICK:      next_state = (pick_rem == '0) ? UPDATE : GRANT;
      GRANT:     if (grant_ready) next_state = WAIT_DONE;
      WAIT_DONE: if (burst_done) next_state = UPDATE;
      UPDATE:    next_state = any_after ? PICK : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_valid_d = (next_state == GRANT);
    ch_done_d     = (state == UPDATE) && upd_done;
    ch_id_d       = ch_done_d ? grant_ch : '0;
    wtd_d         = ((state == IDLE) && arbitrate && !any_pending) ||
                    ((state == UPDATE) && !any_after);
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      grant_valid              <= 1'b0;
      grant_ch                 <= '0;
      grant_beats              <= '0;
      ch_done                  <= 1'b0;
      ch_id                    <= '0;
      arbWriteTransactionsDone <= 1'b0;
    end else begin
      grant_valid              <= grant_valid_d;
      ch_done                  <= ch_done_d;
      ch_id                    <= ch_id_d;
      arbWriteTransactionsDone <= wtd_d;
      if (state == PICK) begin
        grant_ch    <= CH_ID_W'(pick_win);
        grant_beats <= pick_beats;
      end
    end
  end

`ifdef DMA_ARB_ROUND_ROBIN_EN
  // Pointer tracks the last channel that actually received a grant.
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn)                           last_q <= IDX_W'(NUM_CHANNELS - 1);
    else if ((state == PICK) && (pick_rem != '0)) last_q <= pick_win;
  end
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter; honours DMA_ARB_ROUND_ROBIN_EN.
module tb_dma_channel_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arbSample;
  logic [5:0]  arbCurrentChannelSample;
  logic [3:0]  arbChannelPriority;
  logic [31:0] arbChannelTransferSize;
  logic        arbitrate;
  logic        grant_valid;
  logic        grant_ready;
  logic [5:0]  grant_ch;
  logic [4:0]  grant_beats;
  logic        burst_done;
  logic        ch_done;
  logic [5:0]  ch_id;
  logic        wtd;

  int errors = 0;
  int checks = 0;

  dma_channel_arbiter dut (
    .AXI_aclk                 (clk),
    .AXI_aresetn              (rstn),
    .arbSample                (arbSample),
    .arbCurrentChannelSample  (arbCurrentChannelSample),
    .arbChannelPriority       (arbChannelPriority),
    .arbChannelTransferSize   (arbChannelTransferSize),
    .arbitrate                (arbitrate),
    .grant_valid              (grant_valid),
    .grant_ready              (grant_ready),
    .grant_ch                 (grant_ch),
    .grant_beats              (grant_beats),
    .burst_done               (burst_done),
    .ch_done                  (ch_done),
    .ch_id                    (ch_id),
    .arbWriteTransactionsDone (wtd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [5:0] id, input logic [3:0] pr, input logic [31:0] sz);
    arbSample               = 1'b1;
    arbCurrentChannelSample = id;
    arbChannelPriority      = pr;
    arbChannelTransferSize  = sz;
    tick();
    arbSample = 1'b0;
  endtask

  task automatic pulse_arbitrate();
    arbitrate = 1'b1;
    tick();
    arbitrate = 1'b0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      if (grant_valid) break;
      tick();
    end
    chk("grant_seen", 32'(grant_valid), 32'd1);
  endtask

  // One full grant/burst round, checking the completion pulses it must leave behind.
  task automatic do_burst(input logic [5:0] ech, input logic [4:0] eb,
                          input logic edone, input logic [5:0] eid, input logic ewtd);
    wait_grant();
    chk("grant_ch", 32'(grant_ch), 32'(ech));
    chk("grant_beats", 32'(grant_beats), 32'(eb));
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("valid_drop", 32'(grant_valid), 32'd0);
    tick();
    tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("done_early", 32'(ch_done), 32'd0);
    tick();
    chk("ch_done", 32'(ch_done), 32'(edone));
    if (edone) chk("ch_id", 32'(ch_id), 32'(eid));
    chk("wtd", 32'(wtd), 32'(ewtd));
  endtask

  initial begin
    rstn = 1'b0;
    arbSample = 1'b0;
    arbCurrentChannelSample = '0;
    arbChannelPriority = '0;
    arbChannelTransferSize = '0;
    arbitrate = 1'b0;
    grant_ready = 1'b0;
    burst_done = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_ch", 32'(grant_ch), 32'd0);
    chk("rst_beats", 32'(grant_beats), 32'd0);
    chk("rst_done", 32'(ch_done), 32'd0);
    chk("rst_id", 32'(ch_id), 32'd0);
    chk("rst_wtd", 32'(wtd), 32'd0);
    rstn = 1'b1;
    tick();

    // Single channel split into 16/16/8.
    sample(6'd3, 4'd2, 32'd40);
    pulse_arbitrate();
    chk("lat_pick", 32'(grant_valid), 32'd0);
    tick();
    chk("lat_grant", 32'(grant_valid), 32'd1);
    do_burst(6'd3, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd3, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd3, 5'd8,  1'b1, 6'd3, 1'b1);
    tick();
    chk("done_pulse_w", 32'(ch_done), 32'd0);
    chk("wtd_pulse_w", 32'(wtd), 32'd0);

    // Priority ordering.
    sample(6'd1, 4'd1, 32'd4);
    sample(6'd7, 4'd5, 32'd4);
    pulse_arbitrate();
    do_burst(6'd7, 5'd4, 1'b1, 6'd7, 1'b0);
    do_burst(6'd1, 5'd4, 1'b1, 6'd1, 1'b1);

    // Equal-priority tie-break.
    sample(6'd2, 4'd3, 32'd32);
    sample(6'd5, 4'd3, 32'd32);
    pulse_arbitrate();
`ifdef DMA_ARB_ROUND_ROBIN_EN
    do_burst(6'd2, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd5, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd2, 5'd16, 1'b1, 6'd2, 1'b0);
    do_burst(6'd5, 5'd16, 1'b1, 6'd5, 1'b1);
`else
    do_burst(6'd2, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd2, 5'd16, 1'b1, 6'd2, 1'b0);
    do_burst(6'd5, 5'd16, 1'b0, 6'd0, 1'b0);
    do_burst(6'd5, 5'd16, 1'b1, 6'd5, 1'b1);
`endif

    // Backpressure: grant held stable, then zero-size preemption during WAIT_DONE.
    sample(6'd4, 4'd1, 32'd20);
    pulse_arbitrate();
    wait_grant();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(grant_valid), 32'd1);
      chk("stall_ch", 32'(grant_ch), 32'd4);
      chk("stall_beats", 32'(grant_beats), 32'd16);
      tick();
    end
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("stall_accept", 32'(grant_valid), 32'd0);
    sample(6'd9, 4'd7, 32'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    tick();
    chk("ch4_not_done", 32'(ch_done), 32'd0);
    tick();
    chk("zero_no_done_yet", 32'(ch_done), 32'd0);
    chk("zero_no_grant", 32'(grant_valid), 32'd0);
    tick();
    chk("zero_done", 32'(ch_done), 32'd1);
    chk("zero_id", 32'(ch_id), 32'd9);
    chk("zero_wtd", 32'(wtd), 32'd0);
    chk("zero_no_grant2", 32'(grant_valid), 32'd0);
    do_burst(6'd4, 5'd4, 1'b1, 6'd4, 1'b1);

    // Async reset mid-grant, then out-of-range sample is dropped.
    sample(6'd6, 4'd1, 32'd8);
    pulse_arbitrate();
    wait_grant();
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(grant_valid), 32'd0);
    chk("arst_ch", 32'(grant_ch), 32'd0);
    chk("arst_beats", 32'(grant_beats), 32'd0);
    #2 rstn = 1'b1;
    tick();
    sample(6'd40, 4'd3, 32'd5);
    pulse_arbitrate();
    chk("empty_wtd", 32'(wtd), 32'd1);
    chk("empty_valid", 32'(grant_valid), 32'd0);
    tick();
    chk("empty_wtd_w", 32'(wtd), 32'd0);
    chk("empty_valid2", 32'(grant_valid), 32'd0);
    tick();
    chk("empty_valid3", 32'(grant_valid), 32'd0);
    chk("empty_done", 32'(ch_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
